alu_reg_file: RTL and testbench

Execution datapath for the multi-cycle RV32I core. It combines a 32×32-bit general-purpose register file, reached through a single-master Wishbone-style request/acknowledge port, with a purely combinational integer ALU and branch comparator. The CPU sequencer reads rs1/rs2 and writes rd through the register port, and drives the ALU directly from its latched operands and instruction fields.

---
 rtl/alu_reg_file.sv | 96 +++++++++
 tb/tb_alu_reg_file.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_reg_file.sv
// RV32I execution datapath: 32x32 register file behind a single-master
// request/ack port, plus a stateless integer ALU and branch comparator.
module alu_reg_file (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic [31:0] o_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_op,
    input  logic        i_sub,
    input  logic        i_arith_shift,
    input  logic [2:0]  i_branch_op,
    output logic [31:0] o_y,
    output logic        o_will_branch
);

    logic [31:0] r_regs [0:31];
    logic [31:0] r_wb_data;
    logic        r_wb_ack;
    logic [4:0]  w_idx;
    logic        w_accept;
    logic        w_unused_addr;

    assign w_idx         = i_wb_addr[4:0];
    assign w_unused_addr = ^i_wb_addr[31:5];
    assign o_wb_stall    = 1'b0;
    assign w_accept      = i_wb_stb && !o_wb_stall;

    // Writes to x0 are dropped and x0 reads are forced to zero, so entry 0 stays 0.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++)
                r_regs[i] <= '0;
            r_wb_data <= '0;
            r_wb_ack  <= 1'b0;
        end else begin
            r_wb_ack <= w_accept;
            if (w_accept) begin
                if (i_wb_we) begin
                    if (w_idx != 5'd0)
                        r_regs[w_idx] <= i_wb_data;
                end else begin
                    r_wb_data <= (w_idx == 5'd0) ? 32'd0 : r_regs[w_idx];
                end
            end
        end
    end

    assign o_wb_data = r_wb_data;
    assign o_wb_ack  = r_wb_ack;

    logic [4:0] w_shamt;
    logic       w_eq;
    logic       w_lt;
    logic       w_ltu;

    assign w_shamt = i_b[4:0];
    assign w_eq    = (i_a == i_b);
    assign w_lt    = ($signed(i_a) < $signed(i_b));
    assign w_ltu   = (i_a < i_b);

    always_comb begin
        o_y = '0;
        case (i_op)
            3'b000:  o_y = i_sub ? (i_a - i_b) : (i_a + i_b);
            3'b001:  o_y = i_a << w_shamt;
            3'b010:  o_y = {31'd0, w_lt};
            3'b011:  o_y = {31'd0, w_ltu};
            3'b100:  o_y = i_a ^ i_b;
            3'b101:  o_y = i_arith_shift ? $unsigned($signed(i_a) >>> w_shamt)
                                         : (i_a >> w_shamt);
            3'b110:  o_y = i_a | i_b;
            default: o_y = i_a & i_b;
        endcase
    end

    always_comb begin
        o_will_branch = 1'b0;
        case (i_branch_op)
            3'b000:  o_will_branch = w_eq;
            3'b001:  o_will_branch = !w_eq;
            3'b100:  o_will_branch = w_lt;
            3'b101:  o_will_branch = !w_lt;
            3'b110:  o_will_branch = w_ltu;
            3'b111:  o_will_branch = !w_ltu;
            default: o_will_branch = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_reg_file.sv
// Bench for alu_reg_file: register-port scoreboard plus a table of ALU/branch vectors.
module tb_alu_reg_file;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [31:0] i_wb_addr;
    logic [31:0] i_wb_data;
    logic [31:0] o_wb_data;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic [2:0]  i_op;
    logic        i_sub;
    logic        i_arith_shift;
    logic [2:0]  i_branch_op;
    logic [31:0] o_y;
    logic        o_will_branch;

    alu_reg_file dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr),
        .i_wb_data(i_wb_data), .o_wb_data(o_wb_data), .o_wb_ack(o_wb_ack),
        .o_wb_stall(o_wb_stall), .i_a(i_a), .i_b(i_b), .i_op(i_op),
        .i_sub(i_sub), .i_arith_shift(i_arith_shift), .i_branch_op(i_branch_op),
        .o_y(o_y), .o_will_branch(o_will_branch)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model of the register file and the scoreboard of expected read data.
    logic [31:0] m_regs [0:31];
    logic [31:0] m_last;
    logic [31:0] exp_q [$];

    // Every cycle: an ack is due exactly when a request was queued for the previous edge.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (exp_q.size() > 0) begin
                chk("wb_ack", {31'd0, o_wb_ack}, 32'd1);
                chk("wb_data", o_wb_data, exp_q.pop_front());
            end else begin
                chk("wb_ack_idle", {31'd0, o_wb_ack}, 32'd0);
            end
            chk("wb_stall", {31'd0, o_wb_stall}, 32'd0);
        end
    end

    task automatic wb(input logic we, input logic [31:0] addr, input logic [31:0] data);
        @(negedge i_clk);
        i_wb_stb  = 1'b1;
        i_wb_we   = we;
        i_wb_addr = addr;
        i_wb_data = data;
        if (we) begin
            if (addr[4:0] != 5'd0) m_regs[addr[4:0]] = data;
        end else begin
            m_last = (addr[4:0] == 5'd0) ? 32'd0 : m_regs[addr[4:0]];
        end
        exp_q.push_back(m_last);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            i_wb_stb = 1'b0;
            i_wb_we  = 1'b0;
        end
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic [2:0]  op;
        logic        sub, ar;
        logic [2:0]  bop;
        logic [31:0] y;
        logic        br;
    } vec_t;

    vec_t vecs [17];

    initial begin
        i_reset = 1'b1; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        i_wb_addr = '0; i_wb_data = '0;
        i_a = '0; i_b = '0; i_op = '0; i_sub = 1'b0; i_arith_shift = 1'b0; i_branch_op = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_last = '0;

        vecs[0]  = '{32'd5,        32'd3,        3'b000, 1'b1, 1'b0, 3'b000, 32'd2,        1'b0};
        vecs[1]  = '{32'hFFFFFFFF, 32'd1,        3'b000, 1'b0, 1'b0, 3'b001, 32'd0,        1'b1};
        vecs[2]  = '{32'hFFFFFFFF, 32'd1,        3'b010, 1'b0, 1'b0, 3'b100, 32'd1,        1'b1};
        vecs[3]  = '{32'hFFFFFFFF, 32'd1,        3'b011, 1'b0, 1'b0, 3'b110, 32'd0,        1'b0};
        vecs[4]  = '{32'h80000000, 32'd4,        3'b101, 1'b0, 1'b1, 3'b101, 32'hF8000000, 1'b0};
        vecs[5]  = '{32'h80000000, 32'd4,        3'b101, 1'b0, 1'b0, 3'b111, 32'h08000000, 1'b1};
        vecs[6]  = '{32'd1,        32'h21,       3'b001, 1'b0, 1'b0, 3'b010, 32'd2,        1'b0};
        vecs[7]  = '{32'hFFFFFFFE, 32'd1,        3'b100, 1'b0, 1'b0, 3'b000, 32'hFFFFFFFF, 1'b0};
        vecs[8]  = '{32'hFFFFFFFE, 32'd1,        3'b110, 1'b0, 1'b0, 3'b001, 32'hFFFFFFFF, 1'b1};
        vecs[9]  = '{32'hFFFFFFFE, 32'd1,        3'b111, 1'b0, 1'b0, 3'b100, 32'd0,        1'b1};
        vecs[10] = '{32'hFFFFFFFE, 32'd1,        3'b000, 1'b1, 1'b0, 3'b101, 32'hFFFFFFFD, 1'b0};
        vecs[11] = '{32'hFFFFFFFE, 32'd1,        3'b010, 1'b0, 1'b0, 3'b110, 32'd1,        1'b0};
        vecs[12] = '{32'hFFFFFFFE, 32'd1,        3'b011, 1'b0, 1'b0, 3'b111, 32'd0,        1'b1};
        vecs[13] = '{32'hFFFFFFFE, 32'd1,        3'b001, 1'b1, 1'b1, 3'b011, 32'hFFFFFFFC, 1'b0};
        vecs[14] = '{32'h12345678, 32'h12345678, 3'b100, 1'b0, 1'b1, 3'b000, 32'd0,        1'b1};
        vecs[15] = '{32'hF0000000, 32'h24,       3'b101, 1'b0, 1'b1, 3'b010, 32'hFF000000, 1'b0};
        vecs[16] = '{32'd3,        32'd5,        3'b000, 1'b0, 1'b1, 3'b001, 32'd8,        1'b1};

        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        idle(1);

        // Basic reads/writes, x0 behaviour, upper address bits ignored.
        wb(1'b0, 32'd5, 32'd0);            idle(2);
        wb(1'b1, 32'd7, 32'hDEADBEEF);     idle(1);
        wb(1'b0, 32'd7, 32'd0);            idle(1);
        wb(1'b1, 32'd0, 32'h12345678);     idle(1);
        wb(1'b0, 32'd0, 32'd0);            idle(1);
        wb(1'b0, 32'h27, 32'd0);           idle(1);

        // Back-to-back including read-after-write on the very next edge.
        wb(1'b1, 32'd9,  32'hCAFEF00D);
        wb(1'b0, 32'd9,  32'd0);
        wb(1'b1, 32'd31, 32'h0BADBEEF);
        wb(1'b0, 32'd31, 32'd0);
        wb(1'b0, 32'd7,  32'd0);
        idle(2);

        // Request presented during reset is dropped and registers clear.
        @(negedge i_clk);
        i_reset = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
        i_wb_addr = 32'd7; i_wb_data = 32'h55555555;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_last = '0;
        @(negedge i_clk);
        i_reset = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        idle(1);
        chk("rst_data", o_wb_data, 32'd0);
        wb(1'b0, 32'd7, 32'd0);            idle(1);
        wb(1'b0, 32'd9, 32'd0);            idle(2);

        for (int i = 0; i < 17; i++) begin
            i_a = vecs[i].a; i_b = vecs[i].b; i_op = vecs[i].op;
            i_sub = vecs[i].sub; i_arith_shift = vecs[i].ar; i_branch_op = vecs[i].bop;
            #1;
            chk($sformatf("alu_y[%0d]", i), o_y, vecs[i].y);
            chk($sformatf("branch[%0d]", i), {31'd0, o_will_branch}, {31'd0, vecs[i].br});
        end

        idle(3);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
